// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine: FSM states, one-hot change
// codes and coin values in half-units.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VEND,
    WAIT_DROP,
    PAY_ONE,
    PAY_HALF,
    FAULT
  } vend_state_e;

  localparam logic [2:0] CHG_HALF     = 3'b001;
  localparam logic [2:0] CHG_ONE      = 3'b010;
  localparam logic [2:0] CHG_ONE_HALF = 3'b100;

  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;

  // Non-one-hot patterns decode to zero so they add nothing to credit.
  function automatic logic [1:0] chg_decode(input logic [2:0] chg);
    case (chg)
      CHG_HALF:     return 2'd1;
      CHG_ONE:      return 2'd2;
      CHG_ONE_HALF: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Request/actuator/handshake bundle between the coin FSM side and the dispense
// back end.
interface vend_dispense_ctrl_if;
  import vend_pkg::*;

  logic                         pi_beverage;
  logic [$bits(CHG_HALF)-1:0]   pi_change;
  logic                         pi_drop_sense;
  logic                         pi_coin_ack;
  logic                         po_motor_on;
  logic                         po_eject_one;
  logic                         po_eject_half;
  logic                         po_busy;
  logic                         po_overflow;
  logic                         po_fault;

  modport master (
    output pi_beverage, pi_change, pi_drop_sense, pi_coin_ack,
    input  po_motor_on, po_eject_one, po_eject_half, po_busy, po_overflow, po_fault
  );

  modport slave (
    input  pi_beverage, pi_change, pi_drop_sense, pi_coin_ack,
    output po_motor_on, po_eject_one, po_eject_half, po_busy, po_overflow, po_fault
  );

endinterface

// File: rtl/vend_sat_counter.sv
// Up/down counter that applies add and consume as one net update, clamps at
// all-ones and strobes ovf when an add is clipped.
module vend_sat_counter #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         clr,
  input  logic [W-1:0] inc,
  input  logic [W-1:0] dec,
  output logic [W-1:0] count,
  output logic         ovf
);

  // Two guard bits: bit W flags a result above max, bit W+1 a negative result.
  logic [W+1:0] sum;

  always_comb sum = {2'b00, count} + {2'b00, inc} - {2'b00, dec};

  always_ff @(posedge sys_clk) begin
    if (sys_rst)        count <= '0;
    else if (clr)       count <= '0;
    else if (sum[W+1])  count <= '0;
    else if (sum[W])    count <= '1;
    else                count <= sum[W-1:0];
  end

  assign ovf = !sys_rst && !clr && !sum[W+1] && sum[W];

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense back end: queues beverage/change requests and sequences motor and coin
// ejectors. Optional drop timeout enabled by `define VEND_DROP_TIMEOUT_EN.
//  state     | meaning
//  IDLE      | pick next job: beverage, then 1.0 coin, then 0.5 coin
//  VEND      | motor on for MOTOR_CYCLES
//  WAIT_DROP | motor off, wait for chute sensor
//  PAY_ONE   | eject 1.0 coin until ack
//  PAY_HALF  | eject 0.5 coin until ack
//  FAULT     | drop timed out; held until reset
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 50,
  parameter int DROP_TIMEOUT = 200,
  parameter int CREDIT_W     = 4,
  parameter int BEV_CNT_W    = 2
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  vend_dispense_ctrl_if.slave bus
);

  localparam int TMR_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  vend_state_e          state, state_nxt;
  logic [TMR_W-1:0]     tmr, tmr_nxt;
  logic [CREDIT_W-1:0]  credit, credit_add, credit_sub;
  logic [BEV_CNT_W-1:0] bev_cnt, bev_add, bev_sub;
  logic                 credit_ovf, bev_ovf, fault_trip, overflow_q;

  assign credit_add = CREDIT_W'(chg_decode(bus.pi_change));
  assign bev_add    = BEV_CNT_W'(bus.pi_beverage);

  vend_sat_counter #(.W(CREDIT_W)) u_credit (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (1'b0),
    .inc     (credit_add),
    .dec     (credit_sub),
    .count   (credit),
    .ovf     (credit_ovf)
  );

  vend_sat_counter #(.W(BEV_CNT_W)) u_bev_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (fault_trip),
    .inc     (bev_add),
    .dec     (bev_sub),
    .count   (bev_cnt),
    .ovf     (bev_ovf)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      tmr        <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (credit_ovf || bev_ovf) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    credit_sub = '0;
    bev_sub    = '0;
    fault_trip = 1'b0;
    case (state)
      IDLE: begin
        if (bev_cnt != '0) begin
          state_nxt = VEND;
          tmr_nxt   = TMR_W'(MOTOR_CYCLES - 1);
        end else if (credit >= CREDIT_W'(COIN_ONE)) begin
          state_nxt = PAY_ONE;
        end else if (credit == CREDIT_W'(COIN_HALF)) begin
          state_nxt = PAY_HALF;
        end
      end
      VEND: begin
        if (tmr == '0) begin
          state_nxt = WAIT_DROP;
          tmr_nxt   = TMR_W'(DROP_TIMEOUT - 1);
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      WAIT_DROP: begin
        if (bus.pi_drop_sense) begin
          bev_sub   = BEV_CNT_W'(1);
          state_nxt = IDLE;
        end
`ifdef VEND_DROP_TIMEOUT_EN
        else if (tmr == '0) begin
          fault_trip = 1'b1;
          state_nxt  = FAULT;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
`endif
      end
      PAY_ONE: begin
        if (bus.pi_coin_ack) begin
          credit_sub = CREDIT_W'(COIN_ONE);
          state_nxt  = IDLE;
        end
      end
      PAY_HALF: begin
        if (bus.pi_coin_ack) begin
          credit_sub = CREDIT_W'(COIN_HALF);
          state_nxt  = IDLE;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef VEND_DROP_TIMEOUT_EN
  logic fault_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)         fault_q <= 1'b0;
    else if (fault_trip) fault_q <= 1'b1;
  end

  assign bus.po_fault = fault_q;
`else
  assign bus.po_fault = 1'b0;
`endif

  assign bus.po_motor_on   = (state == VEND);
  assign bus.po_eject_one  = (state == PAY_ONE);
  assign bus.po_eject_half = (state == PAY_HALF);
  assign bus.po_busy       = (state != IDLE) || (credit != '0) || (bev_cnt != '0);
  assign bus.po_overflow   = overflow_q;

endmodule
